// File: rtl/switch_conditioner_pkg.sv
// Shared constants and helpers for the switch conditioning stage.
// Default debounce depth targets the board clock; the SIM_ value keeps simulations short.
package switch_conditioner_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 1000;
    localparam int SIM_DEBOUNCE_CYCLES = 4;

    // Counter width able to hold values up to `cycles`.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// Single-bit synchroniser + debounce counter with registered rise/fall pulses.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
module debounce_bit
    import switch_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   level_reg, level_next;
    logic                   rise_reg, rise_next;
    logic                   fall_reg, fall_next;

    assign s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], raw};
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    // Any matching cycle drops the partial count, so short bounces never propagate.
    always_comb begin
        level_next = level_reg;
        cnt_next   = '0;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (s != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = s;
                rise_next  = s;
                fall_next  = ~s;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;
    assign busy  = |cnt_reg;

endmodule

// File: rtl/switch_conditioner.sv
// Conditions NUM_IN raw switch inputs into clean levels and edge pulses.
// Define SWITCH_CONDITIONER_TOGGLE_EN to turn each clean output into a push-on/push-off toggle.
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int NUM_IN          = 3,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] sw_raw,
    output logic [NUM_IN-1:0] sw_clean,
    output logic [NUM_IN-1:0] sw_rise,
    output logic [NUM_IN-1:0] sw_fall,
    output logic              stable
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("switch_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [NUM_IN-1:0] level_w;
    logic [NUM_IN-1:0] busy_w;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (sw_raw[gi]),
            .level (level_w[gi]),
            .rise  (sw_rise[gi]),
            .fall  (sw_fall[gi]),
            .busy  (busy_w[gi])
        );
    end

    assign stable = ~|busy_w;

`ifdef SWITCH_CONDITIONER_TOGGLE_EN
    logic [NUM_IN-1:0] toggle_reg;

    // Flips on the cycle after each debounced press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_reg <= '0;
        end else begin
            toggle_reg <= toggle_reg ^ sw_rise;
        end
    end

    assign sw_clean = toggle_reg;
`else
    assign sw_clean = level_w;
`endif

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Input-conditioning stage ahead of the combinational logic tasks.
- Takes raw, asynchronous, bouncing slide-switch/push-button levels from the board.
- Synchronises and debounces each bit, then drives clean levels plus one-cycle edge pulses.
- The clean levels drive the logic inputs a, b, c directly.

Parameters:
- NUM_IN, 3, number of independent switch inputs.
- SYNC_STAGES, 2, flip-flop depth of the per-bit synchroniser; legal values ≥2.
- DEBOUNCE_CYCLES, 1000, consecutive mismatching clock cycles required to accept a new level; legal values ≥1.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw_raw  input  NUM_IN  raw asynchronous switch levels.
- sw_clean  output  NUM_IN  debounced level, registered; feeds {c,b,a} = sw_clean[2:0].
- sw_rise  output  NUM_IN  one-cycle pulse when sw_clean bit goes 0→1.
- sw_fall  output  NUM_IN  one-cycle pulse when sw_clean bit goes 1→0.
- stable  output  1  high when every debounce counter is zero (no pending change).

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_n low immediately clears all state, independent of clk.
- Reset values:
  - synchroniser FFs, debounced state and counters = 0.
  - sw_clean = 0, sw_rise = 0, sw_fall = 0, stable = 1.
- Synchroniser: sw_raw[i] passes through SYNC_STAGES FFs; the last stage output is s[i].
- Debounce, per bit, with d[i] = debounced state and cnt[i] of width $clog2(DEBOUNCE_CYCLES+1):
  - s==d: cnt ← 0.
  - s!=d and cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - s!=d and cnt == DEBOUNCE_CYCLES-1: d ← s, cnt ← 0, and the matching rise/fall pulse is registered high for exactly one cycle, coincident with the d change.
- Any cycle with s==d during counting discards the partial count, so bounce shorter than DEBOUNCE_CYCLES produces no output change.
- Latency: a raw level held stable appears on sw_clean exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- DEBOUNCE_CYCLES = 1 degenerates to registered synchroniser output with 1 extra cycle.
- Bits are fully independent. Simultaneous changes on several bits update in the same cycle, and rise and fall pulses for different bits may coincide.
- sw_rise[i] and sw_fall[i] are never both high.
- stable = ~|cnt, registered together with cnt (same cycle as the counter state).
- A level present at reset release is treated as a change from 0 and is accepted after the normal latency.
- Reset mid-count aborts the count; counting restarts from 0 after release.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Elaboration-time check: $error if SYNC_STAGES<2 or DEBOUNCE_CYCLES<1.

Optional Feature:
- Macro: SWITCH_CONDITIONER_TOGGLE_EN.
- Defined:
  - sw_clean[i] is a toggle latch that inverts on every sw_rise[i] pulse, turning momentary push-buttons into on/off switches.
  - The toggle updates one cycle after the rise pulse.
  - sw_rise/sw_fall still reflect the debounced level, not the toggle.
  - The toggle latch resets to 0.
- Undefined: sw_clean = d (plain debounced level); no toggle registers are instantiated.

Decomposition:
- Package switch_conditioner_pkg:
  - default constants SYNC_STAGES_DEF = 2, DEBOUNCE_CYCLES_DEF = 1000, SIM_DEBOUNCE_CYCLES = 4.
  - function cnt_width(cycles) returning $clog2(cycles+1).
- Sub-module debounce_bit:
  - one synchroniser chain, counter and edge pulses for a single bit.
  - instantiated NUM_IN times in a generate loop.
- Top level: the generate loop, the stable reduction, and the optional toggle latches.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset: hold rst_n=0 with sw_raw=3'b111 for 5 cycles → sw_clean=000, sw_rise=sw_fall=000, stable=1. Then release → sw_clean=111 exactly 6 edges later, with sw_rise=111 for one cycle.
- Clean step: sw_raw[0] 0→1 and held → sw_clean[0]=1 and sw_rise[0] pulse at edge 6; stable=0 during edges 3–5; no other bit changes.
- Bounce: sw_raw[1] high for 3 cycles then low, repeated 4 times → sw_clean[1] stays 0, no pulses. Then a 10-cycle hold high → accepted at edge 6 of the hold.
- Simultaneous: from sw_clean=010, sw_raw 010→100 in one cycle → same edge sw_clean=100, sw_rise=100, sw_fall=010.
- Reset mid-operation: sw_raw[2]=1, assert rst_n=0 asynchronously between edges 4 and 5 → outputs clear immediately, before the next clk edge. Release → sw_clean[2]=1 after a full 6-edge latency, not early.
- Toggle (macro defined): two debounced presses of sw_raw[0] (10 cycles high, 10 low, each) → sw_clean[0] goes 1 after the first press, 0 after the second; sw_fall[0] still pulses on each release.
